// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control inputs and measurement results between a host and pwm_capture.
interface pwm_capture_if #(parameter int RESOLUTION = 16);
  logic                  enable;
  logic                  sigin;
  logic                  clr_ovf;
  logic [RESOLUTION-1:0] onperiod;
  logic [RESOLUTION-1:0] offperiod;
  logic                  valid;
  logic                  overflow;
  logic                  active;
  modport master (
    output enable, sigin, clr_ovf,
    input  onperiod, offperiod, valid, overflow, active
  );
  modport slave (
    input  enable, sigin, clr_ovf,
    output onperiod, offperiod, valid, overflow, active
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high/low durations of an asynchronous input in clkin ticks (reported as ticks - 1).
module pwm_capture #(
  parameter int RESOLUTION = 16
) (
  input logic         clkin,
  input logic         rst,
  pwm_capture_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_RISE, HIGH, LOW} state_e;
  state_e                state_q;
  logic                  s1_q, s2_q, s3_q;
  logic [RESOLUTION-1:0] cnt_q, on_cap_q, onperiod_q, offperiod_q;
  logic                  valid_q, overflow_q, active_q;
  logic                  rise, fall, lvl, cnt_max;
  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign lvl     = s2_q;
  assign cnt_max = &cnt_q;
  assign bus.onperiod  = onperiod_q;
  assign bus.offperiod = offperiod_q;
  assign bus.valid     = valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.active    = active_q;
  // A level that saturates the counter abandons the period and re-arms, so a clear racing it loses
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      on_cap_q    <= '0;
      onperiod_q  <= '0;
      offperiod_q <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      s1_q    <= bus.sigin;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      valid_q <= 1'b0;
      if (bus.clr_ovf) overflow_q <= 1'b0;
      if (!bus.enable) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        on_cap_q <= '0;
        active_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= ARM;
          ARM: if (!lvl) state_q <= WAIT_RISE;
          WAIT_RISE: if (rise) begin
            state_q  <= HIGH;
            cnt_q    <= '0;
            active_q <= 1'b1;
          end
          HIGH: if (fall) begin
            on_cap_q <= cnt_q;
            cnt_q    <= '0;
            state_q  <= LOW;
          end else if (cnt_max) begin
            overflow_q <= 1'b1;
            state_q    <= ARM;
            cnt_q      <= '0;
            active_q   <= 1'b0;
          end else cnt_q <= cnt_q + RESOLUTION'(1);
          LOW: if (rise) begin
            onperiod_q  <= on_cap_q;
            offperiod_q <= cnt_q;
            valid_q     <= 1'b1;
            cnt_q       <= '0;
            state_q     <= HIGH;
          end else if (cnt_max) begin
            overflow_q <= 1'b1;
            state_q    <= ARM;
            cnt_q      <= '0;
            active_q   <= 1'b0;
          end else cnt_q <= cnt_q + RESOLUTION'(1);
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed waveforms checked against a run-length model of the capture rules.
module tb_pwm_capture;
  logic clkin = 1'b0;
  logic rst;
  pwm_capture_if #(.RESOLUTION(16)) bus ();
  pwm_capture #(.RESOLUTION(16)) dut (.clkin(clkin), .rst(rst), .bus(bus.slave));
  always #5 clkin = ~clkin;
  int n_chk = 0;
  int n_fail = 0;
  int last_on = 0;
  int last_off = 0;
  int ovf_at = -1;
  bit wq[$];
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clkin);
    #1;
  endtask
  task automatic push_run(input bit lvl, input int len);
    for (int i = 0; i < len; i++) wq.push_back(lvl);
  endtask
  // Disable, settle the input at lvl, then enable; held results must survive the idle time
  task automatic prep(input bit lvl);
    bus.enable = 1'b0;
    bus.sigin  = lvl;
    repeat (3) begin
      step();
      check("dis_valid", bus.valid, 0);
    end
    check("dis_on", bus.onperiod, last_on);
    check("dis_off", bus.offperiod, last_off);
    check("dis_active", bus.active, 0);
    bus.enable = 1'b1;
    repeat (5) begin
      step();
      check("arm_valid", bus.valid, 0);
    end
  endtask
  // Model: every rise after a start rise reports the preceding high/low run lengths minus one,
  // two edges after the input is first sampled high; any run over 2^16 ticks voids that period.
  task automatic run_wave();
    int n;
    int pr;
    int fl;
    bit ev[];
    int eon[];
    int eoff[];
    n = wq.size();
    pr = -1;
    fl = -1;
    ev = new[n + 4];
    eon = new[n + 4];
    eoff = new[n + 4];
    for (int t = 1; t < n; t++) begin
      if (wq[t] && !wq[t-1]) begin
        if (pr >= 0 && fl > pr && fl - pr <= 65536 && t - fl <= 65536) begin
          ev[t+2] = 1'b1;
          eon[t+2] = fl - pr - 1;
          eoff[t+2] = t - fl - 1;
        end
        pr = t;
      end
      if (!wq[t] && wq[t-1]) fl = t;
    end
    for (int t = 0; t < n + 4; t++) begin
      bus.sigin = wq[(t < n) ? t : n - 1];
      bus.clr_ovf = (t == ovf_at);
      step();
      if (t == ovf_at - 1) check("ovf_before", bus.overflow, 0);
      if (t == ovf_at) check("ovf_set_wins", bus.overflow, 1);
      check("valid", bus.valid, ev[t]);
      if (ev[t]) begin
        check("onperiod", bus.onperiod, eon[t]);
        check("offperiod", bus.offperiod, eoff[t]);
        last_on = eon[t];
        last_off = eoff[t];
      end
    end
    bus.clr_ovf = 1'b0;
    ovf_at = -1;
  endtask
  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.sigin = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (3) step();
    check("rst_on", bus.onperiod, 0);
    check("rst_off", bus.offperiod, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_active", bus.active, 0);
    rst = 1'b0;
    // 5 high / 3 low
    prep(1'b0);
    wq.delete();
    push_run(1'b0, 6);
    repeat (6) begin push_run(1'b1, 5); push_run(1'b0, 3); end
    push_run(1'b1, 5);
    run_wave();
    check("t1_on", last_on, 4);
    check("t1_off", last_off, 2);
    check("t1_active", bus.active, 1);
    // generator loopback 100/37
    prep(1'b0);
    wq.delete();
    push_run(1'b0, 6);
    repeat (4) begin push_run(1'b1, 101); push_run(1'b0, 38); end
    push_run(1'b1, 5);
    run_wave();
    check("t2_on", last_on, 100);
    check("t2_off", last_off, 37);
    // minimum levels
    prep(1'b0);
    wq.delete();
    push_run(1'b0, 6);
    repeat (10) begin push_run(1'b1, 1); push_run(1'b0, 1); end
    push_run(1'b1, 1);
    run_wave();
    check("t3_on", last_on, 0);
    check("t3_off", last_off, 0);
    // random waveforms, random starting level
    for (int r = 0; r < 6; r++) begin
      bit lvl;
      bit cur;
      lvl = 1'($urandom_range(0, 1));
      prep(lvl);
      wq.delete();
      push_run(lvl, $urandom_range(2, 10));
      cur = !lvl;
      for (int k = 0; k < 24; k++) begin
        push_run(cur, $urandom_range(1, 30));
        cur = !cur;
      end
      run_wave();
    end
    // enabled while high, then disabled mid-HIGH
    prep(1'b1);
    wq.delete();
    push_run(1'b1, 10);
    push_run(1'b0, 4);
    repeat (3) begin push_run(1'b1, 5); push_run(1'b0, 3); end
    push_run(1'b1, 40);
    run_wave();
    check("t5_on", last_on, 4);
    check("t5_active", bus.active, 1);
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.sigin = 1'(i / 2);
      step();
      check("t5_dis_valid", bus.valid, 0);
      check("t5_dis_on", bus.onperiod, last_on);
      check("t5_dis_off", bus.offperiod, last_off);
    end
    check("t5_dis_active", bus.active, 0);
    // overflow on a long high, with a clear pulse coinciding with the set
    prep(1'b0);
    check("ovf_init", bus.overflow, 0);
    wq.delete();
    push_run(1'b0, 6);
    push_run(1'b1, 65600);
    push_run(1'b0, 3);
    repeat (4) begin push_run(1'b1, 5); push_run(1'b0, 3); end
    push_run(1'b1, 5);
    ovf_at = 6 + 65538;
    run_wave();
    check("t4_on", last_on, 4);
    check("t4_off", last_off, 2);
    check("ovf_sticky", bus.overflow, 1);
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    check("ovf_cleared", bus.overflow, 0);
    // reset in LOW while a rise is in the synchronizer
    prep(1'b0);
    wq.delete();
    push_run(1'b0, 6);
    repeat (2) begin push_run(1'b1, 5); push_run(1'b0, 3); end
    push_run(1'b0, 4);
    run_wave();
    check("t6_active", bus.active, 1);
    bus.sigin = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    check("t6_valid", bus.valid, 0);
    check("t6_on", bus.onperiod, 0);
    check("t6_off", bus.offperiod, 0);
    check("t6_ovf", bus.overflow, 0);
    check("t6_active", bus.active, 0);
    rst = 1'b0;
    repeat (4) begin
      step();
      check("t6_post_valid", bus.valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
